mips_multicycle_controller: RTL
===============================

# mips_multicycle_controller

Control unit for the multi-cycle MIPS core, the successor to the single-cycle `Controller`. It sequences each instruction through fetch, decode, execute, memory and writeback states over a shared datapath. It waits on a memory ready handshake with a parametrised wait-state timeout, and provides an error trap and an instruction-retire counter. It sits beside the multi-cycle datapath inside the core top and drives all of its mux selects and write enables.

## Interface
- `MEM_TIMEOUT`, 16: maximum cycles a memory state may wait for `mem_ready`. A value of 0 disables the timeout.
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `opcode` input 6: instruction register bits [31:26].
- `func` input 6: instruction register bits [5:0].
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory has completed the current read or write this cycle.
- `mem_read`, `mem_write` output 1: memory request strobes.
- `i_or_d` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_write`, `pc_write`, `reg_write` output 1: register write enables.
- `alu_src_a` output 1: ALU input A select; 0 = PC, 1 = register A.
- `alu_src_b` output 2: ALU input B select; 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_op` output 3: 000 add, 001 sub, 010 and, 011 or, 100 slt.
- `pc_src` output 2: next-PC select; 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A.
- `reg_dst` output 2: destination register select; 00 = rt, 01 = rd, 10 = $31.
- `wb_sel` output 2: writeback data select; 00 = ALUOut, 01 = MDR, 10 = PC.
- `retire` output 1: one-cycle pulse in the final state of each instruction.
- `instr_count` output CNT_W: number of instructions retired.
- `err` output 1: sticky memory-timeout flag.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, BRANCH, IEXE, IWB, JUMP, JR, HALT.
- Outputs not listed for a state are 0 in that state.
- FETCH:
  - Asserts `mem_read`, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, add.
  - `ir_write` and `pc_write` are asserted only in the cycle where `mem_ready`=1.
  - On `mem_ready` the FSM goes to DECODE; otherwise it stays in FETCH.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, add (precomputes the branch target). Next state by opcode:
  - 100011 (lw) and 101011 (sw) go to MEMADR.
  - 000000 goes to JR if `func`=001000, otherwise to RTEXE.
  - 000100 (beq) and 000101 (bne) go to BRANCH.
  - 001000 (addi) and 001010 (slti) go to IEXE.
  - 000010 (j) and 000011 (jal) go to JUMP.
  - Any other opcode is a NOP: `retire` is asserted and the FSM returns to FETCH.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_read`, `i_or_d`=1. Waits for `mem_ready`, then goes to MEMWB.
- MEMWB: `reg_write`, `reg_dst`=00, `wb_sel`=01, `retire`. Goes to FETCH.
- MEMWR: `mem_write`, `i_or_d`=1. Waits for `mem_ready`; `retire` is asserted in the `mem_ready` cycle, then the FSM goes to FETCH.
- RTEXE: `alu_src_a`=1, `alu_src_b`=00. `alu_op` from `func`:
  - 100000 → add, 100010 → sub, 100100 → and, 100101 → or, 101010 → slt.
  - Any other `func` → add.
- RTWB: `reg_write`, `reg_dst`=01, `wb_sel`=00, `retire`. Goes to FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, sub, `pc_src`=01, `retire`. Goes to FETCH.
  - `pc_write` = (beq & `zero`) | (bne & ~`zero`), combinational in this state.
- IEXE: `alu_src_a`=1, `alu_src_b`=10; add for addi, slt for slti. Goes to IWB.
- IWB: `reg_write`, `reg_dst`=00, `wb_sel`=00, `retire`. Goes to FETCH.
- JUMP: `pc_src`=10, `pc_write`, `retire`. Goes to FETCH.
  - For jal, also `reg_write`, `reg_dst`=10, `wb_sel`=10; PC already holds PC+4.
- JR: `pc_src`=11, `pc_write`, `retire`. Goes to FETCH.
- Timeout (FETCH, MEMRD, MEMWR only):
  - `wait_cnt` clears on entry to a memory state and increments each cycle `mem_ready`=0.
  - If `MEM_TIMEOUT`>0 and `wait_cnt` reaches `MEM_TIMEOUT` with `mem_ready` still 0, the next state is HALT and `err` sets.
  - `mem_ready`=1 in the same cycle wins over the timeout.
- HALT: all strobes 0. HALT is absorbing; only `rst` exits it.
- `instr_count` increments on every `retire` and wraps modulo 2^CNT_W.

## Timing
- Reset: state=FETCH, `wait_cnt`=0, `instr_count`=0, `err`=0. While `rst`=1, every output is forced to 0.
- The first `mem_read` appears in the first cycle after `rst` deasserts.
- CPI with zero wait states (`mem_ready` always 1):
  - lw = 5; sw, R-type and addi/slti = 4; beq/bne, j/jal and jr = 3; unknown opcode = 2.
- Each memory wait cycle adds 1 cycle to the instruction.
- `retire` and the `instr_count` update share the same clock edge; the new count is visible the following cycle.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.

## Test plan
- Reset, then lw with `mem_ready`=1 throughout → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; `retire` pulses in cycle 5; `instr_count`=1.
- R-type with `func`=100010 → `alu_op`=001 in RTEXE; RTWB drives `reg_dst`=01 and `reg_write`=1.
- beq with `zero`=1 → `pc_write`=1 in BRANCH. bne with `zero`=1 → `pc_write`=0. Both take 3 cycles.
- jal → `pc_write`, `reg_write`, `reg_dst`=10 and `wb_sel`=10 all high in JUMP. jr (opcode 000000, `func` 001000) → `pc_src`=11.
- `MEM_TIMEOUT`=4, sw with `mem_ready` held 0 in MEMWR → FSM enters HALT after 4 wait cycles; `err`=1 and stays 1; later `mem_ready` pulses have no effect.
- Assert `rst` mid-MEMRD → all outputs 0 immediately; after release, FETCH with `mem_read`=1 and `instr_count`=0.

Source files
------------

// File: rtl/mips_multicycle_controller_if.sv
// Control bundle between the multi-cycle controller and the datapath/memory.
// The master side is the controller.
interface mips_multicycle_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       func;
  logic             zero;
  logic             mem_ready;
  logic             mem_read;
  logic             mem_write;
  logic             i_or_d;
  logic             ir_write;
  logic             pc_write;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_op;
  logic [1:0]       pc_src;
  logic [1:0]       reg_dst;
  logic [1:0]       wb_sel;
  logic             retire;
  logic [CNT_W-1:0] instr_count;
  logic             err;

  modport master (
    input  opcode, func, zero, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, reg_dst, wb_sel,
           retire, instr_count, err
  );

  modport slave (
    output opcode, func, zero, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, reg_dst, wb_sel,
           retire, instr_count, err
  );
endinterface

// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// traps memory-ready timeouts into a sticky HALT, and counts retired instructions.
module mips_multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  mips_multicycle_controller_if.master  bus
);
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] AOP_ADD = 3'b000;
  localparam logic [2:0] AOP_SUB = 3'b001;
  localparam logic [2:0] AOP_AND = 3'b010;
  localparam logic [2:0] AOP_OR  = 3'b011;
  localparam logic [2:0] AOP_SLT = 3'b100;

  // Counter only needs to hold 0..MEM_TIMEOUT-1; the last value arms the trap.
  localparam int unsigned WAIT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTEXE,
    S_RTWB, S_BRANCH, S_IEXE, S_IWB, S_JUMP, S_JR, S_HALT
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;

  logic       mr, mw, iod, irw, pcw, rw, asa, ret, timeout_hit, wait_last, mem_state;
  logic [1:0] asb, psrc, rdst, wbs;
  logic [2:0] aop;

  assign wait_last = (MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_W'(TO_LAST));
  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  always_comb begin
    state_d     = state_q;
    mr          = 1'b0;
    mw          = 1'b0;
    iod         = 1'b0;
    irw         = 1'b0;
    pcw         = 1'b0;
    rw          = 1'b0;
    asa         = 1'b0;
    asb         = 2'b00;
    aop         = AOP_ADD;
    psrc        = 2'b00;
    rdst        = 2'b00;
    wbs         = 2'b00;
    ret         = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_FETCH: begin
        mr  = 1'b1;
        asb = 2'b01;
        if (bus.mem_ready) begin
          irw     = 1'b1;
          pcw     = 1'b1;
          state_d = S_DECODE;
        end else if (wait_last) begin
          timeout_hit = 1'b1;
          state_d     = S_HALT;
        end
      end
      S_DECODE: begin
        asb = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_RTYPE:        state_d = (bus.func == FN_JR) ? S_JR : S_RTEXE;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_ADDI, OP_SLTI: state_d = S_IEXE;
          OP_J, OP_JAL:    state_d = S_JUMP;
          default: begin
            ret     = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        asa     = 1'b1;
        asb     = 2'b10;
        state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mr  = 1'b1;
        iod = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEMWB;
        end else if (wait_last) begin
          timeout_hit = 1'b1;
          state_d     = S_HALT;
        end
      end
      S_MEMWB: begin
        rw      = 1'b1;
        wbs     = 2'b01;
        ret     = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        mw  = 1'b1;
        iod = 1'b1;
        if (bus.mem_ready) begin
          ret     = 1'b1;
          state_d = S_FETCH;
        end else if (wait_last) begin
          timeout_hit = 1'b1;
          state_d     = S_HALT;
        end
      end
      S_RTEXE: begin
        asa = 1'b1;
        case (bus.func)
          6'b100010: aop = AOP_SUB;
          6'b100100: aop = AOP_AND;
          6'b100101: aop = AOP_OR;
          6'b101010: aop = AOP_SLT;
          default:   aop = AOP_ADD;
        endcase
        state_d = S_RTWB;
      end
      S_RTWB: begin
        rw      = 1'b1;
        rdst    = 2'b01;
        ret     = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        asa     = 1'b1;
        aop     = AOP_SUB;
        psrc    = 2'b01;
        ret     = 1'b1;
        pcw     = ((bus.opcode == OP_BEQ) &&  bus.zero) ||
                  ((bus.opcode == OP_BNE) && !bus.zero);
        state_d = S_FETCH;
      end
      S_IEXE: begin
        asa     = 1'b1;
        asb     = 2'b10;
        aop     = (bus.opcode == OP_SLTI) ? AOP_SLT : AOP_ADD;
        state_d = S_IWB;
      end
      S_IWB: begin
        rw      = 1'b1;
        ret     = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        psrc = 2'b10;
        pcw  = 1'b1;
        ret  = 1'b1;
        if (bus.opcode == OP_JAL) begin
          rw   = 1'b1;
          rdst = 2'b10;
          wbs  = 2'b10;
        end
        state_d = S_FETCH;
      end
      S_JR: begin
        psrc    = 2'b11;
        pcw     = 1'b1;
        ret     = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    if (state_d != state_q)             wait_cnt_d = '0;
    else if (mem_state && !bus.mem_ready) wait_cnt_d = wait_cnt_q + 1'b1;
    else                                 wait_cnt_d = wait_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (ret) cnt_q <= cnt_q + 1'b1;
      err_q      <= err_q | timeout_hit;
    end
  end

  // State decodes as FETCH during reset, so combinational outputs are masked by rst.
  assign bus.mem_read    = mr  & ~rst;
  assign bus.mem_write   = mw  & ~rst;
  assign bus.i_or_d      = iod & ~rst;
  assign bus.ir_write    = irw & ~rst;
  assign bus.pc_write    = pcw & ~rst;
  assign bus.reg_write   = rw  & ~rst;
  assign bus.alu_src_a   = asa & ~rst;
  assign bus.alu_src_b   = rst ? '0 : asb;
  assign bus.alu_op      = rst ? '0 : aop;
  assign bus.pc_src      = rst ? '0 : psrc;
  assign bus.reg_dst     = rst ? '0 : rdst;
  assign bus.wb_sel      = rst ? '0 : wbs;
  assign bus.retire      = ret & ~rst;
  assign bus.instr_count = cnt_q;
  assign bus.err         = err_q;
endmodule
